// File: rtl/cdma_addr_guard.sv
// cdma_addr_guard: AXI4 address window checker between the remapped CDMA
// master and the memory interconnect. In-window transactions pass through
// unchanged; out-of-window transactions are answered locally with DECERR and
// recorded in the error registers. The internal FSM states and the in-flight
// counters are also brought out on dbg_* ports.
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both high at the rising edge; valid never waits on ready.
module cdma_addr_guard #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ID_WIDTH        = 4,
  parameter int                    USER_WIDTH      = 1,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE        = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK        = 32'h8000_0000,
  parameter int                    MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  // slave side (from CDMA remap)
  input  logic [ID_WIDTH-1:0]                s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]              s_axi_awaddr,
  input  logic [7:0]                         s_axi_awlen,
  input  logic [2:0]                         s_axi_awsize,
  input  logic [1:0]                         s_axi_awburst,
  input  logic                               s_axi_awlock,
  input  logic [3:0]                         s_axi_awcache,
  input  logic [2:0]                         s_axi_awprot,
  input  logic [3:0]                         s_axi_awqos,
  input  logic [USER_WIDTH-1:0]              s_axi_awuser,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [DATA_WIDTH-1:0]              s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]            s_axi_wstrb,
  input  logic                               s_axi_wlast,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [ID_WIDTH-1:0]                s_axi_bid,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [ID_WIDTH-1:0]                s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic [7:0]                         s_axi_arlen,
  input  logic [2:0]                         s_axi_arsize,
  input  logic [1:0]                         s_axi_arburst,
  input  logic                               s_axi_arlock,
  input  logic [3:0]                         s_axi_arcache,
  input  logic [2:0]                         s_axi_arprot,
  input  logic [3:0]                         s_axi_arqos,
  input  logic [USER_WIDTH-1:0]              s_axi_aruser,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [ID_WIDTH-1:0]                s_axi_rid,
  output logic [DATA_WIDTH-1:0]              s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rlast,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  // master side (to interconnect)
  output logic [ID_WIDTH-1:0]                m_axi_awid,
  output logic [ADDR_WIDTH-1:0]              m_axi_awaddr,
  output logic [7:0]                         m_axi_awlen,
  output logic [2:0]                         m_axi_awsize,
  output logic [1:0]                         m_axi_awburst,
  output logic                               m_axi_awlock,
  output logic [3:0]                         m_axi_awcache,
  output logic [2:0]                         m_axi_awprot,
  output logic [3:0]                         m_axi_awqos,
  output logic [USER_WIDTH-1:0]              m_axi_awuser,
  output logic                               m_axi_awvalid,
  input  logic                               m_axi_awready,
  output logic [DATA_WIDTH-1:0]              m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]            m_axi_wstrb,
  output logic                               m_axi_wlast,
  output logic                               m_axi_wvalid,
  input  logic                               m_axi_wready,
  input  logic [ID_WIDTH-1:0]                m_axi_bid,
  input  logic [1:0]                         m_axi_bresp,
  input  logic                               m_axi_bvalid,
  output logic                               m_axi_bready,
  output logic [ID_WIDTH-1:0]                m_axi_arid,
  output logic [ADDR_WIDTH-1:0]              m_axi_araddr,
  output logic [7:0]                         m_axi_arlen,
  output logic [2:0]                         m_axi_arsize,
  output logic [1:0]                         m_axi_arburst,
  output logic                               m_axi_arlock,
  output logic [3:0]                         m_axi_arcache,
  output logic [2:0]                         m_axi_arprot,
  output logic [3:0]                         m_axi_arqos,
  output logic [USER_WIDTH-1:0]              m_axi_aruser,
  output logic                               m_axi_arvalid,
  input  logic                               m_axi_arready,
  input  logic [ID_WIDTH-1:0]                m_axi_rid,
  input  logic [DATA_WIDTH-1:0]              m_axi_rdata,
  input  logic [1:0]                         m_axi_rresp,
  input  logic                               m_axi_rlast,
  input  logic                               m_axi_rvalid,
  output logic                               m_axi_rready,
  // error capture
  output logic [15:0]                        err_count,
  output logic [ADDR_WIDTH-1:0]              err_addr,
  output logic                               err_is_write,
  // debug visibility
  output logic [0:0]                         dbg_rd_state,
  output logic [1:0]                         dbg_wr_state,
  output logic [$clog2(MAX_OUTSTANDING):0]   dbg_rd_cnt,
  output logic [$clog2(MAX_OUTSTANDING):0]   dbg_wr_cnt
);

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_ERR   = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DRAIN = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [0:0]            rd_state_q, rd_state_d;
  logic [1:0]            wr_state_q, wr_state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      w_pend_q, w_pend_d;
  logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [7:0]            rd_beat_q, rd_beat_d;
  logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_is_write_q, err_is_write_d;

  logic ar_hit, aw_hit;
  logic rd_miss_hs, wr_miss_hs;
  logic aw_hit_hs, w_last_fwd;
  logic [16:0] err_sum;

  assign ar_hit = (s_axi_araddr & WIN_MASK) == WIN_BASE;
  assign aw_hit = (s_axi_awaddr & WIN_MASK) == WIN_BASE;

  // Request and write-data payloads are forwarded as-is; only valid/ready are gated.
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_awuser  = s_axi_awuser;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;
  assign m_axi_aruser  = s_axi_aruser;

  assign err_count    = err_count_q;
  assign err_addr     = err_addr_q;
  assign err_is_write = err_is_write_q;
  assign dbg_rd_state = rd_state_q;
  assign dbg_wr_state = wr_state_q;
  assign dbg_rd_cnt   = rd_cnt_q;
  assign dbg_wr_cnt   = wr_cnt_q;

  // Read path: AR gating, R passthrough, and local DECERR burst generation.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_id_d       = rd_id_q;
    rd_len_d      = rd_len_q;
    rd_beat_d     = rd_beat_q;
    rd_miss_hs    = 1'b0;
    m_axi_arvalid = 1'b0;
    s_axi_arready = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rid     = m_axi_rid;
    s_axi_rdata   = m_axi_rdata;
    s_axi_rresp   = m_axi_rresp;
    s_axi_rlast   = m_axi_rlast;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hit) begin
          m_axi_arvalid = s_axi_arvalid && (rd_cnt_q < CNT_MAX);
          s_axi_arready = m_axi_arready && (rd_cnt_q < CNT_MAX);
        end else begin
          // A miss waits for all forwarded reads to drain so its error
          // response cannot overtake one of them.
          s_axi_arready = (rd_cnt_q == '0);
          if (s_axi_arvalid && (rd_cnt_q == '0)) begin
            rd_miss_hs = 1'b1;
            rd_id_d    = s_axi_arid;
            rd_len_d   = s_axi_arlen;
            rd_beat_d  = 8'd0;
            rd_state_d = R_ERR;
          end
        end
        s_axi_rvalid = m_axi_rvalid;
        m_axi_rready = s_axi_rready;
      end
      default: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = rd_id_q;
        s_axi_rdata  = '0;
        s_axi_rresp  = 2'b11;
        s_axi_rlast  = (rd_beat_q == rd_len_q);
        if (s_axi_rready) begin
          if (rd_beat_q == rd_len_q) rd_state_d = R_IDLE;
          else                       rd_beat_d  = rd_beat_q + 8'd1;
        end
      end
    endcase
    if (reset) begin
      m_axi_arvalid = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      m_axi_rready  = 1'b0;
      rd_miss_hs    = 1'b0;
    end
  end

  // Write path: AW gating, W forwarding/draining, B passthrough or DECERR.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_id_d       = wr_id_q;
    wr_miss_hs    = 1'b0;
    aw_hit_hs     = 1'b0;
    w_last_fwd    = 1'b0;
    m_axi_awvalid = 1'b0;
    s_axi_awready = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = m_axi_bvalid;
    s_axi_bid     = m_axi_bid;
    s_axi_bresp   = m_axi_bresp;
    m_axi_bready  = s_axi_bready;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hit) begin
          m_axi_awvalid = s_axi_awvalid && (wr_cnt_q < CNT_MAX);
          s_axi_awready = m_axi_awready && (wr_cnt_q < CNT_MAX);
          aw_hit_hs     = s_axi_awvalid && m_axi_awready && (wr_cnt_q < CNT_MAX);
        end else begin
          s_axi_awready = (wr_cnt_q == '0) && (w_pend_q == '0);
          if (s_axi_awvalid && (wr_cnt_q == '0) && (w_pend_q == '0)) begin
            wr_miss_hs = 1'b1;
            wr_id_d    = s_axi_awid;
            wr_state_d = W_DRAIN;
          end
        end
        // W only moves once its AW has been forwarded (or is this cycle).
        if ((w_pend_q != '0) || aw_hit_hs) begin
          m_axi_wvalid = s_axi_wvalid;
          s_axi_wready = m_axi_wready;
          w_last_fwd   = s_axi_wvalid && m_axi_wready && s_axi_wlast;
        end
      end
      W_DRAIN: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) wr_state_d = W_RESP;
      end
      default: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = wr_id_q;
        s_axi_bresp  = 2'b11;
        m_axi_bready = 1'b0;
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
    endcase
    if (reset) begin
      m_axi_awvalid = 1'b0;
      s_axi_awready = 1'b0;
      m_axi_wvalid  = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      wr_miss_hs    = 1'b0;
      aw_hit_hs     = 1'b0;
      w_last_fwd    = 1'b0;
    end
  end

  // Outstanding counters: forwarded reads, forwarded writes, writes awaiting W data.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    w_pend_d = w_pend_q;
    case ({m_axi_arvalid && m_axi_arready, m_axi_rvalid && m_axi_rready && m_axi_rlast})
      2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
    case ({m_axi_awvalid && m_axi_awready, m_axi_bvalid && m_axi_bready})
      2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
      default: wr_cnt_d = wr_cnt_q;
    endcase
    case ({aw_hit_hs, w_last_fwd})
      2'b10:   w_pend_d = w_pend_q + 1'b1;
      2'b01:   w_pend_d = w_pend_q - 1'b1;
      default: w_pend_d = w_pend_q;
    endcase
  end

  // Error capture: saturating count; a same-cycle write miss wins the address.
  always_comb begin
    err_sum        = {1'b0, err_count_q} + {16'd0, rd_miss_hs} + {16'd0, wr_miss_hs};
    err_count_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    err_addr_d     = err_addr_q;
    err_is_write_d = err_is_write_q;
    if (wr_miss_hs) begin
      err_addr_d     = s_axi_awaddr;
      err_is_write_d = 1'b1;
    end else if (rd_miss_hs) begin
      err_addr_d     = s_axi_araddr;
      err_is_write_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q     <= R_IDLE;
      wr_state_q     <= W_IDLE;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      w_pend_q       <= '0;
      rd_id_q        <= '0;
      rd_len_q       <= '0;
      rd_beat_q      <= '0;
      wr_id_q        <= '0;
      err_count_q    <= '0;
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      wr_state_q     <= wr_state_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      w_pend_q       <= w_pend_d;
      rd_id_q        <= rd_id_d;
      rd_len_q       <= rd_len_d;
      rd_beat_q      <= rd_beat_d;
      wr_id_q        <= wr_id_d;
      err_count_q    <= err_count_d;
      err_addr_q     <= err_addr_d;
      err_is_write_q <= err_is_write_d;
    end
  end

endmodule

// File: tb/tb_cdma_addr_guard.sv
// Directed testbench for cdma_addr_guard with hand-computed expectations.
module tb_cdma_addr_guard;

  logic clk = 1'b0;
  logic reset;

  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_rlast, s_axi_rvalid, s_axi_rready;

  logic [3:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic [0:0]  m_axi_awuser, m_axi_aruser;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic        err_is_write;
  logic [0:0]  dbg_rd_state;
  logic [1:0]  dbg_wr_state;
  logic [3:0]  dbg_rd_cnt, dbg_wr_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  cdma_addr_guard dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(3'd3), .s_axi_awburst(2'b01), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0),
    .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awuser(1'b0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(3'd3), .s_axi_arburst(2'b01), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0),
    .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_aruser(1'b0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_count(err_count), .err_addr(err_addr), .err_is_write(err_is_write),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state),
    .dbg_rd_cnt(dbg_rd_cnt), .dbg_wr_cnt(dbg_wr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    s_axi_arvalid = v; s_axi_araddr = a; s_axi_arid = id; s_axi_arlen = len;
  endtask

  task automatic drive_aw(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    s_axi_awvalid = v; s_axi_awaddr = a; s_axi_awid = id; s_axi_awlen = len;
  endtask

  task automatic drive_w(input logic v, input logic [63:0] d, input logic last);
    s_axi_wvalid = v; s_axi_wdata = d; s_axi_wlast = last; s_axi_wstrb = 8'hFF;
  endtask

  task automatic drive_r(input logic v, input logic [63:0] d, input logic [3:0] id, input logic last);
    m_axi_rvalid = v; m_axi_rdata = d; m_axi_rid = id; m_axi_rlast = last; m_axi_rresp = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    drive_ar(0, 0, 0, 0); drive_aw(0, 0, 0, 0); drive_w(0, 0, 0); drive_r(0, 0, 0, 0);
    s_axi_rready = 1'b1; s_axi_bready = 1'b0;
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bid = 0; m_axi_bresp = 0;

    // handshakes are blocked while reset is high
    tick();
    drive_ar(1, 32'h8000_0000, 0, 0); m_axi_arready = 1'b1; m_axi_rvalid = 1'b1;
    #1;
    check_eq("rst_m_arvalid", m_axi_arvalid, 0);
    check_eq("rst_s_arready", s_axi_arready, 0);
    check_eq("rst_s_rvalid", s_axi_rvalid, 0);
    drive_ar(0, 0, 0, 0); m_axi_rvalid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_err_addr", err_addr, 0);
    check_eq("rst_err_is_write", err_is_write, 0);
    check_eq("rst_states", {dbg_rd_state, dbg_wr_state}, 0);
    check_eq("rst_cnts", {dbg_rd_cnt, dbg_wr_cnt}, 0);

    // hit read, len 3, forwarded unchanged
    tick();
    drive_ar(1, 32'h8000_1000, 4'd1, 8'd3);
    #1;
    check_eq("hit_m_arvalid", m_axi_arvalid, 1);
    check_eq("hit_m_araddr", m_axi_araddr, 32'h8000_1000);
    check_eq("hit_m_arlen", m_axi_arlen, 3);
    check_eq("hit_s_arready", s_axi_arready, 1);
    tick();
    drive_ar(0, 0, 0, 0);
    #1;
    check_eq("hit_rd_cnt1", dbg_rd_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      drive_r(1, 64'hA0 + 64'(i), 4'd1, i == 3);
      #1;
      check_eq("hit_r_valid", s_axi_rvalid, 1);
      check_eq("hit_r_data", s_axi_rdata, 64'hA0 + 64'(i));
      check_eq("hit_r_last", s_axi_rlast, (i == 3));
      tick();
    end
    drive_r(0, 0, 0, 0);
    #1;
    check_eq("hit_rd_cnt0", dbg_rd_cnt, 0);
    check_eq("hit_err_count", err_count, 0);

    // miss read, len 7, id 5: eight DECERR beats
    drive_ar(1, 32'h0000_2000, 4'd5, 8'd7);
    #1;
    check_eq("rmiss_m_arvalid", m_axi_arvalid, 0);
    check_eq("rmiss_s_arready", s_axi_arready, 1);
    tick();
    drive_ar(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("rmiss_rvalid", s_axi_rvalid, 1);
      check_eq("rmiss_rresp", s_axi_rresp, 2'b11);
      check_eq("rmiss_rid", s_axi_rid, 5);
      check_eq("rmiss_rdata", s_axi_rdata, 0);
      check_eq("rmiss_rlast", s_axi_rlast, (i == 7));
      check_eq("rmiss_m_arvalid_err", m_axi_arvalid, 0);
      tick();
    end
    #1;
    check_eq("rmiss_done_rvalid", s_axi_rvalid, 0);
    check_eq("rmiss_state", dbg_rd_state, 0);
    check_eq("rmiss_err_count", err_count, 1);
    check_eq("rmiss_err_addr", err_addr, 32'h0000_2000);
    check_eq("rmiss_err_is_write", err_is_write, 0);

    // miss write, len 1, id 2; W presented together with AW; bready stalled
    drive_aw(1, 32'h0000_4000, 4'd2, 8'd1);
    drive_w(1, 64'h11, 0);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    #1;
    check_eq("wmiss_m_awvalid", m_axi_awvalid, 0);
    check_eq("wmiss_s_awready", s_axi_awready, 1);
    check_eq("wmiss_w_stalled", s_axi_wready, 0);
    check_eq("wmiss_m_wvalid0", m_axi_wvalid, 0);
    tick();
    drive_aw(0, 0, 0, 0);
    #1;
    check_eq("wmiss_drain_state", dbg_wr_state, 1);
    check_eq("wmiss_drain_wready", s_axi_wready, 1);
    check_eq("wmiss_m_wvalid1", m_axi_wvalid, 0);
    tick();
    drive_w(1, 64'h22, 1);
    #1;
    check_eq("wmiss_m_wvalid2", m_axi_wvalid, 0);
    tick();
    drive_w(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("wmiss_bvalid_hold", s_axi_bvalid, 1);
      check_eq("wmiss_bresp", s_axi_bresp, 2'b11);
      check_eq("wmiss_bid", s_axi_bid, 2);
      tick();
    end
    s_axi_bready = 1'b1;
    #1;
    check_eq("wmiss_bvalid_last", s_axi_bvalid, 1);
    tick();
    s_axi_bready = 1'b0;
    #1;
    check_eq("wmiss_bvalid_done", s_axi_bvalid, 0);
    check_eq("wmiss_state", dbg_wr_state, 0);
    check_eq("wmiss_err_count", err_count, 2);
    check_eq("wmiss_err_addr", err_addr, 32'h0000_4000);
    check_eq("wmiss_err_is_write", err_is_write, 1);

    // hit write: W before AW stalls, then forwarded alongside the AW
    drive_w(1, 64'h55, 1);
    #1;
    check_eq("whit_w_early_ready", s_axi_wready, 0);
    check_eq("whit_w_early_mvalid", m_axi_wvalid, 0);
    tick();
    drive_aw(1, 32'h8000_0040, 4'd3, 8'd0);
    #1;
    check_eq("whit_m_awvalid", m_axi_awvalid, 1);
    check_eq("whit_s_awready", s_axi_awready, 1);
    check_eq("whit_s_wready", s_axi_wready, 1);
    check_eq("whit_m_wvalid", m_axi_wvalid, 1);
    check_eq("whit_m_wdata", m_axi_wdata, 64'h55);
    tick();
    drive_aw(0, 0, 0, 0); drive_w(0, 0, 0);
    #1;
    check_eq("whit_wr_cnt1", dbg_wr_cnt, 1);
    m_axi_bvalid = 1'b1; m_axi_bid = 4'd3; m_axi_bresp = 2'b00; s_axi_bready = 1'b1;
    #1;
    check_eq("whit_s_bvalid", s_axi_bvalid, 1);
    check_eq("whit_s_bid", s_axi_bid, 3);
    check_eq("whit_s_bresp", s_axi_bresp, 0);
    check_eq("whit_m_bready", m_axi_bready, 1);
    tick();
    m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
    #1;
    check_eq("whit_wr_cnt0", dbg_wr_cnt, 0);

    // eight hit reads fill the window; the ninth waits for an rlast
    for (int i = 0; i < 8; i++) begin
      drive_ar(1, 32'h8000_0000 + 32'(i) * 32'h100, 4'(i), 8'd0);
      exp_q.push_back(32'h8000_0000 + 32'(i) * 32'h100);
      #1;
      check_eq("full_s_arready", s_axi_arready, 1);
      check_eq("full_m_araddr", m_axi_araddr, exp_q.pop_front());
      tick();
    end
    drive_ar(1, 32'h8000_0800, 4'd8, 8'd0);
    exp_q.push_back(32'h8000_0800);
    #1;
    check_eq("full_cnt8", dbg_rd_cnt, 8);
    check_eq("full_stall_arready", s_axi_arready, 0);
    check_eq("full_stall_m_arvalid", m_axi_arvalid, 0);
    tick();
    #1;
    check_eq("full_stall2_arready", s_axi_arready, 0);
    drive_r(1, 64'h0, 4'd0, 1);
    #1;
    check_eq("full_rlast_cycle_arready", s_axi_arready, 0);
    check_eq("full_r_pass", s_axi_rvalid, 1);
    tick();
    drive_r(0, 0, 0, 0);
    #1;
    check_eq("full_after_arready", s_axi_arready, 1);
    check_eq("full_after_m_arvalid", m_axi_arvalid, 1);
    check_eq("full_after_m_araddr", m_axi_araddr, exp_q.pop_front());
    tick();
    drive_ar(0, 0, 0, 0);
    #1;
    check_eq("full_cnt8_again", dbg_rd_cnt, 8);
    drive_r(1, 64'h0, 4'd0, 1);
    repeat (8) tick();
    drive_r(0, 0, 0, 0);
    #1;
    check_eq("full_drained", dbg_rd_cnt, 0);
    check_eq("full_queue_empty", exp_q.size(), 0);

    // miss waits behind an outstanding hit, then its beats follow
    drive_ar(1, 32'h8000_0200, 4'd1, 8'd0);
    tick();
    drive_ar(1, 32'h0000_0100, 4'd6, 8'd1);
    #1;
    check_eq("order_miss_blocked", s_axi_arready, 0);
    check_eq("order_m_arvalid", m_axi_arvalid, 0);
    tick();
    #1;
    check_eq("order_miss_blocked2", s_axi_arready, 0);
    drive_r(1, 64'h77, 4'd1, 1);
    #1;
    check_eq("order_rlast_cycle_arready", s_axi_arready, 0);
    check_eq("order_hit_rid", s_axi_rid, 1);
    tick();
    drive_r(0, 0, 0, 0);
    #1;
    check_eq("order_miss_accept", s_axi_arready, 1);
    tick();
    drive_ar(0, 0, 0, 0);
    #1;
    check_eq("order_beat0_rid", s_axi_rid, 6);
    check_eq("order_beat0_rlast", s_axi_rlast, 0);
    s_axi_rready = 1'b0;
    tick();
    #1;
    check_eq("order_hold_rvalid", s_axi_rvalid, 1);
    check_eq("order_hold_rlast", s_axi_rlast, 0);
    s_axi_rready = 1'b1;
    tick();
    #1;
    check_eq("order_beat1_rlast", s_axi_rlast, 1);
    check_eq("order_beat1_rid", s_axi_rid, 6);
    tick();
    #1;
    check_eq("order_done_rvalid", s_axi_rvalid, 0);
    check_eq("order_err_count", err_count, 3);
    check_eq("order_err_addr", err_addr, 32'h0000_0100);
    check_eq("order_err_is_write", err_is_write, 0);

    // simultaneous read and write miss: +2, write wins the address
    drive_ar(1, 32'h0000_3000, 4'd0, 8'd0);
    drive_aw(1, 32'h0000_5000, 4'd7, 8'd0);
    #1;
    check_eq("dual_arready", s_axi_arready, 1);
    check_eq("dual_awready", s_axi_awready, 1);
    tick();
    drive_ar(0, 0, 0, 0); drive_aw(0, 0, 0, 0);
    #1;
    check_eq("dual_err_count", err_count, 5);
    check_eq("dual_err_addr", err_addr, 32'h0000_5000);
    check_eq("dual_err_is_write", err_is_write, 1);
    check_eq("dual_rlast", s_axi_rlast, 1);
    tick();
    drive_w(1, 64'h99, 1);
    #1;
    check_eq("dual_wready", s_axi_wready, 1);
    tick();
    drive_w(0, 0, 0); s_axi_bready = 1'b1;
    #1;
    check_eq("dual_bvalid", s_axi_bvalid, 1);
    check_eq("dual_bid", s_axi_bid, 7);
    tick();
    s_axi_bready = 1'b0;
    #1;
    check_eq("dual_states", {dbg_rd_state, dbg_wr_state}, 0);

    // saturation at 16'hFFFF
    force dut.err_count_q = 16'hFFFF;
    tick();
    release dut.err_count_q;
    drive_ar(1, 32'h0000_0A00, 4'd1, 8'd0);
    #1;
    check_eq("sat_arready", s_axi_arready, 1);
    tick();
    drive_ar(0, 0, 0, 0);
    #1;
    check_eq("sat_err_count", err_count, 16'hFFFF);
    check_eq("sat_err_addr", err_addr, 32'h0000_0A00);
    tick();

    // reset in the middle of an error burst
    drive_ar(1, 32'h0000_1000, 4'd4, 8'd7);
    tick();
    drive_ar(0, 0, 0, 0);
    #1;
    check_eq("rstmid_burst_on", s_axi_rvalid, 1);
    tick(); tick();
    reset = 1'b1;
    #1;
    check_eq("rstmid_in_reset_rvalid", s_axi_rvalid, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rstmid_after_rvalid", s_axi_rvalid, 0);
    check_eq("rstmid_state", dbg_rd_state, 0);
    check_eq("rstmid_err_count", err_count, 0);
    check_eq("rstmid_err_addr", err_addr, 0);
    tick();
    #1;
    check_eq("rstmid_later_rvalid", s_axi_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
